// File: rtl/i2s_slave_tx.sv
// ---------------------------------------------------------------------------
// i2s_slave_tx
//
// I2S slave transmitter. The bit clock (sck) and word select (ws) come from
// an external master and are oversampled on the system clock. Stereo samples
// come from an upstream valid/ready source through a one-frame holding
// register and are shifted out MSB first on sd, one bit after each ws edge.
//
// Ports
//   ck          system clock (at least 8x the sck frequency)
//   rst         asynchronous, active-high reset
//   sck, ws     I2S bit clock / word select from the master (asynchronous)
//   sd          serial data, updated after sck falls
//   in_left     left sample, two's complement, WIDTH bits
//   in_right    right sample, two's complement, WIDTH bits
//   in_valid    upstream has a sample pair
//   in_ready    holding register empty; pair accepted on in_valid & in_ready
//   underrun    one-ck pulse when a frame starts with the holding reg empty
//   frame_posn  {channel, bit index} of the bit currently on sd; 0 unlocked
// ---------------------------------------------------------------------------
module i2s_slave_tx #(
    parameter int WIDTH = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             sck,
    input  logic             ws,
    output logic             sd,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             underrun,
    output logic [5:0]       frame_posn
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    // [0],[1] synchronise, [2] is the previous value for edge detection
    logic [2:0]       sck_sync_q, sck_sync_d;
    logic [1:0]       ws_sync_q, ws_sync_d;
    logic             sck_rise_q, sck_rise_d;
    logic             sck_fall_q, sck_fall_d;
    logic             ws_q, ws_d;
    logic             chg_pend_q, chg_pend_d;
    state_t           state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_l_q, shift_l_d;
    logic [WIDTH-1:0] shift_r_q, shift_r_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;
    logic             full_q, full_d;
    logic             sd_q, sd_d;
    logic             in_ready_q, in_ready_d;
    logic             underrun_q, underrun_d;
    logic [5:0]       frame_posn_q, frame_posn_d;

    logic             frame_start;
    logic             right_start;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        sck_sync_d   = {sck_sync_q[1:0], sck};
        ws_sync_d    = {ws_sync_q[0], ws};
        sck_rise_d   = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall_d   = ~sck_sync_q[1] & sck_sync_q[2];
        ws_d         = ws_q;
        chg_pend_d   = chg_pend_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        full_d       = full_q;
        sd_d         = sd_q;
        underrun_d   = 1'b0;
        frame_posn_d = frame_posn_q;

        // ws is sampled on sck rise; a changed value is acted on at the next
        // sck fall, giving the I2S one-bit delay before the new MSB.
        if (sck_rise_q) begin
            ws_d       = ws_sync_q[1];
            chg_pend_d = (ws_sync_q[1] != ws_q);
        end else if (sck_fall_q) begin
            chg_pend_d = 1'b0;
        end

        // A 1->0 change starts a frame from any state; 0->1 only from LEFT.
        frame_start = sck_fall_q & chg_pend_q & ~ws_q;
        right_start = sck_fall_q & chg_pend_q & ws_q & (state_q == ST_LEFT);

        if (frame_start) begin
            state_d      = ST_LEFT;
            bit_cnt_d    = 5'd0;
            shift_l_d    = full_q ? hold_l_q : '0;
            shift_r_d    = full_q ? hold_r_q : '0;
            sd_d         = shift_l_d[WIDTH-1];
            underrun_d   = ~full_q;
            frame_posn_d = 6'd0;
            full_d       = 1'b0;
        end else if (right_start) begin
            state_d      = ST_RIGHT;
            bit_cnt_d    = 5'd0;
            sd_d         = shift_r_q[WIDTH-1];
            frame_posn_d = 6'd32;
        end else if (sck_fall_q && state_q != ST_UNLOCKED) begin
            // Zeros shift in behind the sample, so bits past WIDTH and the
            // saturated tail of a long slot are all 0.
            bit_cnt_d = (bit_cnt_q == 5'd31) ? 5'd31 : bit_cnt_q + 5'd1;
            if (state_q == ST_LEFT) begin
                shift_l_d = shift_l_q << 1;
                sd_d      = shift_l_d[WIDTH-1];
            end else begin
                shift_r_d = shift_r_q << 1;
                sd_d      = shift_r_d[WIDTH-1];
            end
            frame_posn_d = {state_q == ST_RIGHT, bit_cnt_d};
        end

        // An accept in the frame-start cycle lands after the transfer has
        // taken the old (empty) contents, so the new pair waits a frame.
        if (in_valid && in_ready_q) begin
            hold_l_d = in_left;
            hold_r_d = in_right;
            full_d   = 1'b1;
        end
        in_ready_d = ~full_d;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    // The holding data is reset too: a mid-frame reset must leave nothing
    // behind that a later frame could transmit.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sck_sync_q   <= '0;
            ws_sync_q    <= '0;
            sck_rise_q   <= 1'b0;
            sck_fall_q   <= 1'b0;
            ws_q         <= 1'b0;
            chg_pend_q   <= 1'b0;
            state_q      <= ST_UNLOCKED;
            bit_cnt_q    <= 5'd0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            full_q       <= 1'b0;
            sd_q         <= 1'b0;
            in_ready_q   <= 1'b1;
            underrun_q   <= 1'b0;
            frame_posn_q <= 6'd0;
        end else begin
            sck_sync_q   <= sck_sync_d;
            ws_sync_q    <= ws_sync_d;
            sck_rise_q   <= sck_rise_d;
            sck_fall_q   <= sck_fall_d;
            ws_q         <= ws_d;
            chg_pend_q   <= chg_pend_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            full_q       <= full_d;
            sd_q         <= sd_d;
            in_ready_q   <= in_ready_d;
            underrun_q   <= underrun_d;
            frame_posn_q <= frame_posn_d;
        end
    end

    assign sd         = sd_q;
    assign in_ready   = in_ready_q;
    assign underrun   = underrun_q;
    assign frame_posn = frame_posn_q;

endmodule

// File: tb/tb_i2s_slave_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_slave_tx
//
// Directed bench for i2s_slave_tx. The bench plays the I2S master: it drives
// sck (8 ck per bit) and ws, samples sd and frame_posn on each sck rise and
// assembles the left/right slot words, which are compared with hand-computed
// sample values. Upstream pairs are pushed through a valid/ready task.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_slave_tx;

    localparam int WIDTH = 16;

    logic             ck = 1'b0;
    logic             rst = 1'b1;
    logic             sck = 1'b1;
    logic             ws = 1'b1;
    logic             sd;
    logic [WIDTH-1:0] in_left = '0;
    logic [WIDTH-1:0] in_right = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             underrun;
    logic [5:0]       frame_posn;

    int          n_tests = 0;
    int          n_fail = 0;
    int          und_cnt = 0;
    int          rdy_low_cnt = 0;
    logic [31:0] lw_acc;
    logic [31:0] rw_acc;
    int          posn_err;
    int          unl_err;
    bit          locked_exp;

    i2s_slave_tx #(.WIDTH(WIDTH)) dut (
        .ck         (ck),
        .rst        (rst),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .underrun   (underrun),
        .frame_posn (frame_posn)
    );

    always #42 ck = ~ck;

    always @(negedge ck) begin
        if (underrun === 1'b1) und_cnt++;
        if (in_ready !== 1'b1) rdy_low_cnt++;
    end

    initial begin
        #(60000 * 84);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One sck period of 8 ck: fall (ws changes with it), sample on rise.
    task automatic sck_cycle(input logic ws_v, output logic sd_s, output logic [5:0] posn_s);
        @(negedge ck);
        sck = 1'b0;
        ws  = ws_v;
        repeat (4) @(negedge ck);
        sd_s   = sd;
        posn_s = frame_posn;
        sck    = 1'b1;
        repeat (3) @(negedge ck);
    endtask

    // Cycles c of a frame with 'slot' bits per channel. Fall c=2*slot drops
    // ws, so the left MSB is sampled at rise 1 of the following frame.
    task automatic run_cycles(input int slot, input int c_from, input int c_to);
        logic       sd_s;
        logic [5:0] p_s;
        logic [5:0] p_exp;
        logic       ws_v;
        int         idx;
        for (int c = c_from; c <= c_to; c++) begin
            ws_v = (c < slot || c == 2 * slot) ? 1'b0 : 1'b1;
            sck_cycle(ws_v, sd_s, p_s);
            if (locked_exp) begin
                if (c <= slot) begin
                    lw_acc = {lw_acc[30:0], sd_s};
                    idx    = (c - 1 > 31) ? 31 : c - 1;
                    p_exp  = {1'b0, 5'(idx)};
                end else begin
                    rw_acc = {rw_acc[30:0], sd_s};
                    idx    = (c - slot - 1 > 31) ? 31 : c - slot - 1;
                    p_exp  = {1'b1, 5'(idx)};
                end
                if (p_s !== p_exp) posn_err++;
            end else if (sd_s !== 1'b0 || p_s !== 6'd0) begin
                unl_err++;
            end
        end
    endtask

    task automatic run_frame(input string name, input int slot,
                             input logic [31:0] exp_l, input logic [31:0] exp_r);
        lw_acc   = '0;
        rw_acc   = '0;
        posn_err = 0;
        run_cycles(slot, 1, 2 * slot);
        check({name, "_left"}, lw_acc, exp_l);
        check({name, "_right"}, rw_acc, exp_r);
        check({name, "_posn_errs"}, 32'(posn_err), 32'd0);
    endtask

    task automatic push(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        int n = 0;
        @(negedge ck);
        while (in_ready !== 1'b1 && n < 4000) begin
            @(negedge ck);
            n++;
        end
        check("push_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        @(negedge ck);
        in_valid = 1'b0;
    endtask

    initial begin
        logic       sd_s;
        logic [5:0] p_s;
        int         u_snap;
        int         r_snap;

        // Reset values, held with ws=1 as if mid right slot.
        repeat (3) @(negedge ck);
        check("rst_sd", {31'd0, sd}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_posn", {26'd0, frame_posn}, 32'd0);
        rst = 1'b0;

        // Lock: hold a sample, sd stays 0 until the first 1->0 ws change.
        push(16'h8234, 16'h8235);
        check("held_in_ready", {31'd0, in_ready}, 32'd0);
        locked_exp = 1'b0;
        unl_err    = 0;
        for (int i = 0; i < 10; i++) begin
            sck_cycle(1'b1, sd_s, p_s);
            if (sd_s !== 1'b0 || p_s !== 6'd0) unl_err++;
        end
        sck_cycle(1'b0, sd_s, p_s);
        if (sd_s !== 1'b0 || p_s !== 6'd0) unl_err++;
        check("unlocked_quiet", 32'(unl_err), 32'd0);

        // Basic frame, then loopback-style stream of incrementing pairs.
        locked_exp = 1'b1;
        fork
            push(16'h8235, 16'h9001);
            run_frame("basic", 32, 32'h8234_0000, 32'h8235_0000);
        join
        fork
            push(16'h8236, 16'h9002);
            run_frame("loop1", 32, 32'h8235_0000, 32'h9001_0000);
        join
        fork
            push(16'h8237, 16'h9003);
            run_frame("loop2", 32, 32'h8236_0000, 32'h9002_0000);
        join
        run_frame("loop3", 32, 32'h8237_0000, 32'h9003_0000);
        check("no_underrun_stream", 32'(und_cnt), 32'd0);

        // Underrun: two empty frames, one pulse each, in_ready stays high.
        r_snap = rdy_low_cnt;
        run_frame("under1", 32, 32'h0, 32'h0);
        check("underrun_cnt1", 32'(und_cnt), 32'd1);
        run_frame("under2", 32, 32'h0, 32'h0);
        check("underrun_cnt2", 32'(und_cnt), 32'd2);
        check("ready_stayed_high", 32'(rdy_low_cnt - r_snap), 32'd0);

        // Short slots: 16-bit slot exactly fits, 12-bit slot truncates, and
        // the following full frame is intact. A pair pushed while the holding
        // register is empty reaches the frame that starts right after.
        fork
            push(16'hA5C3, 16'h5A3C);
            run_frame("slot16", 16, 32'h0000_A5C3, 32'h0000_5A3C);
        join
        fork
            push(16'h1234, 16'hABCD);
            run_frame("slot12", 12, 32'h0000_0123, 32'h0000_0ABC);
        join
        fork
            push(16'h4321, 16'h8765);
            run_frame("after12", 32, 32'h4321_0000, 32'h8765_0000);
        join
        check("no_underrun_short", 32'(und_cnt), 32'd2);

        // Mid-frame reset at left bit 5 with the holding register full.
        u_snap = und_cnt;
        push(16'h1357, 16'h2468);
        lw_acc   = '0;
        rw_acc   = '0;
        posn_err = 0;
        run_cycles(32, 1, 1);
        push(16'hDEAD, 16'hBEEF);
        check("mid_full", {31'd0, in_ready}, 32'd0);
        run_cycles(32, 2, 6);
        check("mid_left_bits", lw_acc, 32'h0000_0004);
        check("mid_posn_errs", 32'(posn_err), 32'd0);
        rst = 1'b1;
        @(negedge ck);
        check("mid_rst_sd", {31'd0, sd}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_posn", {26'd0, frame_posn}, 32'd0);
        rst = 1'b0;
        locked_exp = 1'b0;
        unl_err    = 0;
        push(16'h7FFF, 16'h8001);
        run_cycles(32, 7, 64);
        check("relock_quiet", 32'(unl_err), 32'd0);
        locked_exp = 1'b1;
        run_frame("resume", 32, 32'h7FFF_0000, 32'h8001_0000);
        check("resume_no_underrun", 32'(und_cnt - u_snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_slave_tx.md
# i2s_slave_tx

I2S slave transmitter: the device end of the I2S link that `I2S_CLOCK`/`I2S_RX` master and receive. It takes externally driven `sck`/`ws`, oversamples them on the system clock, and serialises stereo samples onto `sd`. Samples come from an upstream valid/ready source through a one-frame holding register. It is used to emulate a MEMS microphone in the FPGA, or to loop audio back into an `I2S_RX` instance.

## Interface
- `WIDTH`, 16: sample bits per channel, MSB first; range 1..32.
- `ck`  in  1  system clock; must be ≥ 8× the `sck` frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `sck`  in  1  I2S bit clock from the master; asynchronous to `ck`.
- `ws`  in  1  I2S word select from the master: 0 = left, 1 = right; asynchronous to `ck`.
- `sd`  out  1  serial data; changes after `sck` falls, is sampled by the master on `sck` rise.
- `in_left`  in  WIDTH  left sample, two's complement.
- `in_right`  in  WIDTH  right sample, two's complement.
- `in_valid`  in  1  upstream has a sample pair.
- `in_ready`  out  1  holding register empty; the pair is accepted when `in_valid & in_ready` at a `ck` rising edge.
- `underrun`  out  1  one-`ck` pulse when a frame starts with the holding register empty.
- `frame_posn`  out  6  {channel, bit index 0..31} of the bit currently on `sd`; 0 while unlocked.

## Operation
- **Synchronisers:** `sck` and `ws` each pass through a 2-flop synchroniser, then a third flop for edge detection.
  - `sck_rise` and `sck_fall` are one-`ck` strobes.
  - `ws` is captured into `ws_q` on every `sck_rise`.
- **Channel change:** detected on the `sck_rise` where the newly captured `ws` differs from `ws_q`. On the following `sck_fall`, the MSB of the new channel drives `sd` (standard I2S one-bit delay).
- **States:**
  - UNLOCKED: after reset. `sd` = 0. Waits for a detected 1→0 `ws` change.
  - LEFT: entered from any state on a 1→0 change.
  - RIGHT: entered from LEFT on a 0→1 change. A 0→1 change while UNLOCKED is ignored.
- **Frame start** is the `sck_fall` entering LEFT:
  - If the holding register is full, `shift_l`/`shift_r` load from it, the holding register empties, and `in_ready` rises on the next `ck`.
  - If it is empty, both shift registers load 0 and `underrun` pulses.
- **Bit counter:** a 5-bit counter is reset to 0 at each channel start and increments on each `sck_fall`.
  - Bits 0..WIDTH-1 output the channel sample MSB first.
  - Bits WIDTH..31 output 0.
  - At count 31 the counter saturates; `sd` = 0 until the next channel change.
  - A channel change before bit 31 (short slot) truncates the current slot and starts the next one immediately.
- **Right channel:** uses the right sample captured at the same frame start.
- **Holding register:**
  - `in_ready` = !full, registered.
  - Accept and frame-start transfer in the same `ck` cycle: the transfer sees the old contents (empty → underrun), and the newly accepted pair stays held for the next frame.
- **Reset:** asserting `rst` mid-frame forces all outputs to reset values immediately; the block re-locks only on the next 1→0 `ws` change.

## Timing
- **Reset values:** `sd`=0, `in_ready`=1, `underrun`=0, `frame_posn`=0, state UNLOCKED, holding register empty, shift registers 0.
- **`sd` latency:** updates exactly 4 `ck` cycles after the `sck` pin falls (2 sync + 1 edge + 1 output register). With `ck` ≥ 8× `sck` this completes before the next rising edge.
- `frame_posn` updates in the same `ck` cycle as `sd`.
- `underrun` is high for exactly one `ck`, coincident with the frame-start `sd` update.
- `in_ready` falls the `ck` after acceptance and rises the `ck` after the frame-start transfer.
- **Throughput:** one sample pair per `ws` period.

## Test plan
- **Basic frame:** `ck`=12 MHz, `sck`=ck/8, 64 `sck` per frame. Push L=0x8234, R=0x8235 before the first frame. The master-side shift register, sampling `sd` on `sck` rise, reads 32'h82340000 in the left slot and 32'h82350000 in the right slot, with MSB one `sck` after the `ws` edge.
- **Loopback:** drive `sck`/`ws` from `I2S_CLOCK` and connect `sd` to `I2S_RX`, feeding an incrementing pair each frame (L=0x8234+n, R=0x9000+n). From the second frame on, `I2S_RX` left/right equal the values sent, with no `underrun`.
- **Underrun:** stop `in_valid` after 3 frames. Frame 4 transmits all-zero slots; `underrun` pulses exactly once per empty frame and `in_ready` stays 1.
- **Lock:** release reset with `ws`=1 mid right slot. `sd` stays 0 and `frame_posn`=0 until the first 1→0 `ws` change; the first left slot then carries the held sample.
- **Short slot:** `WIDTH`=16 with a 16-`sck` slot (32-`sck` frame). All 16 data bits are sent and the next slot MSB follows with no padding. A 12-`sck` slot truncates after bit 11 without corrupting the next slot.
- **Mid-frame reset:** assert `rst` at left bit 5 with the holding register full. `sd`=0, `in_ready`=1 and the holding register is emptied immediately; transmission resumes correctly at the next left slot after a new sample pair is pushed.
